// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// The master side is the fetch unit itself.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, credit-limited memory requests,
// in-order response queue toward decode, and redirect with in-flight discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   CREDIT   = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc_r;
    logic [31:0]      rsp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] drop_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      q_data_r [DEPTH];
    logic [31:0]      q_pc_r   [DEPTH];

    logic [CNT_W:0]   credit_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             rsp_ok_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic [31:0]      redir_pc_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1'b1);
        end
        return n;
    endfunction

    // Handshake qualification from registered state; a pop never frees credit in its own cycle.
    always_comb begin
        credit_s     = {1'b0, outstanding_r} + {1'b0, count_r};
        head_valid_s = (count_r != {CNT_W{1'b0}});
        req_valid_s  = !rst && !bus.redirect_valid && (credit_s < CREDIT);
        req_fire_s   = req_valid_s && bus.imem_req_ready;
        rsp_ok_s     = bus.imem_rsp_valid && (outstanding_r != {CNT_W{1'b0}});
        push_s       = rsp_ok_s && !bus.redirect_valid && (drop_r == {CNT_W{1'b0}});
        pop_s        = head_valid_s && bus.instr_ready;
        redir_pc_s   = {bus.redirect_pc[31:2], 2'b00};
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_r;
    assign bus.instr_valid    = head_valid_s;
    assign bus.instr          = q_data_r[rd_ptr_r];
    assign bus.instr_pc       = q_pc_r[rd_ptr_r];

    // PC, credit, discard and queue state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_r        <= {CNT_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_data_r[i] <= 32'h0000_0000;
                q_pc_r[i]   <= 32'h0000_0000;
            end
        end else if (bus.redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old path,
            // so drop is rebuilt from outstanding; this keeps drop <= outstanding
            // and makes back-to-back redirects self-consistent.
            pc_r          <= redir_pc_s;
            rsp_pc_r      <= redir_pc_s;
            count_r       <= {CNT_W{1'b0}};
            rd_ptr_r      <= wr_ptr_r;
            outstanding_r <= outstanding_r - CNT_W'(rsp_ok_s);
            drop_r        <= outstanding_r - CNT_W'(rsp_ok_s);
        end else begin
            if (req_fire_s) begin
                pc_r <= pc_r + 32'd4;
            end
            case ({req_fire_s, rsp_ok_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (rsp_ok_s && (drop_r != {CNT_W{1'b0}})) begin
                drop_r <= drop_r - CNT_W'(1'b1);
            end
            if (push_s) begin
                q_data_r[wr_ptr_r] <= bus.imem_rsp_data;
                q_pc_r[wr_ptr_r]   <= rsp_pc_r;
                wr_ptr_r           <= ptr_inc(wr_ptr_r);
                rsp_pc_r           <= rsp_pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
